// File: rtl/qif_pkg.sv
// qif_pkg: shared definitions for the QIF synapse block.
//   - state_t / ST_* : FSM encoding for the step sequencer (IDLE -> ACCUM -> DONE)
//   - I_SYN_W, ACC_W : width of the synaptic current output and the accumulator
//   - sat8()         : clip a signed accumulator value to the signed 8-bit range
//   - is_clipped()   : flag telling whether sat8() changed the value
package qif_pkg;

  localparam int I_SYN_W = 8;
  localparam int ACC_W   = 12;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Clip to [-128, 127].
  function automatic logic [I_SYN_W-1:0] sat8(input logic signed [ACC_W-1:0] v);
    logic [I_SYN_W-1:0] r;
    if (v > 12'sd127) begin
      r = 8'h7F;
    end else if (v < -12'sd128) begin
      r = 8'h80;
    end else begin
      r = v[I_SYN_W-1:0];
    end
    return r;
  endfunction

  // High when the value lies outside the signed 8-bit range.
  function automatic logic is_clipped(input logic signed [ACC_W-1:0] v);
    logic r;
    if ((v > 12'sd127) || (v < -12'sd128)) begin
      r = 1'b1;
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/qif_weight_rf.sv
// qif_weight_rf: NUM_IN x 8-bit signed weight register file.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears every weight)
//   we         : write enable
//   waddr      : write index
//   wdata      : write value
//   raddr      : read index
//   rdata      : combinational read data
module qif_weight_rf
  import qif_pkg::*;
#(
  parameter int NUM_IN = 8,
  localparam int AW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [I_SYN_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [I_SYN_W-1:0] rdata
);

  logic [I_SYN_W-1:0] mem_r [NUM_IN];

  // Weight storage: single write port, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IN; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (we) begin
        mem_r[waddr] <= wdata;
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/qif_synapse.sv
// qif_synapse: spike-driven synaptic current generator for a QIF neuron.
// Each tick the current leaks by i_syn >>> DECAY_SHIFT, then the weights of
// every line that spiked since the previous tick are summed in, one line per
// cycle, and the result is clipped to signed 8 bits.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : block enable (ticks ignored while low in IDLE)
//   tick       : time-step strobe
//   spike_in   : presynaptic spike pulses, bit i = line i
//   cfg_valid / cfg_ready / cfg_addr / cfg_data : weight write handshake
//   i_syn      : signed synaptic current, updated once per step
//   i_valid    : one-cycle pulse when i_syn updates
//   sat        : one-cycle pulse alongside i_valid when the update clipped
//   tick_ovr   : sticky, a tick arrived while a step was in progress
module qif_synapse
  import qif_pkg::*;
#(
  parameter int NUM_IN      = 8,
  parameter int DECAY_SHIFT = 3,
  localparam int AW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               tick,
  input  logic [NUM_IN-1:0]  spike_in,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [I_SYN_W-1:0] cfg_data,
  output logic [I_SYN_W-1:0] i_syn,
  output logic               i_valid,
  output logic               sat,
  output logic               tick_ovr
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_IN - 1);

  state_t                   state_r;
  state_t                   state_next_s;
  logic [AW-1:0]            idx_r;
  logic [NUM_IN-1:0]        pending_r;
  logic [NUM_IN-1:0]        snapshot_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic [I_SYN_W-1:0]       i_syn_r;
  logic                     i_valid_r;
  logic                     sat_r;
  logic                     tick_ovr_r;
  logic                     cfg_ready_r;

  logic                     start_s;
  logic                     we_s;
  logic [I_SYN_W-1:0]       w_rd_s;
  logic signed [ACC_W-1:0]  i_syn_ext_s;
  logic signed [ACC_W-1:0]  decay_s;
  logic signed [ACC_W-1:0]  w_ext_s;

  assign start_s = (state_r == ST_IDLE) && tick && en;
  // cfg_ready is only ever high in IDLE, so weights cannot change mid-step.
  assign we_s    = cfg_valid && cfg_ready_r;

  assign i_syn_ext_s = {{(ACC_W-I_SYN_W){i_syn_r[I_SYN_W-1]}}, i_syn_r};
  assign decay_s     = i_syn_ext_s - (i_syn_ext_s >>> DECAY_SHIFT);
  assign w_ext_s     = {{(ACC_W-I_SYN_W){w_rd_s[I_SYN_W-1]}}, w_rd_s};

  qif_weight_rf #(
    .NUM_IN (NUM_IN)
  ) u_weight_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx_r),
    .rdata (w_rd_s)
  );

  // Step sequencer next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_next_s = ST_ACCUM;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (idx_r == LAST_IDX) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_ACCUM;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register and the registered write-accept flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cfg_ready_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cfg_ready_r <= (state_next_s == ST_IDLE);
    end
  end

  // Spike capture: a spike landing in the tick cycle belongs to the next step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r  <= '0;
      snapshot_r <= '0;
    end else begin
      if (start_s) begin
        snapshot_r <= pending_r;
        pending_r  <= spike_in;
      end else begin
        pending_r  <= pending_r | spike_in;
      end
    end
  end

  // Accumulator: load leaked current, then add one weight per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
      idx_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            acc_r <= decay_s;
            idx_r <= '0;
          end
        end
        ST_ACCUM: begin
          if (snapshot_r[idx_r]) begin
            acc_r <= acc_r + w_ext_s;
          end
          idx_r <= idx_r + AW'(1);
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Output registers: i_syn only moves in DONE, so it holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_syn_r   <= '0;
      i_valid_r <= 1'b0;
      sat_r     <= 1'b0;
    end else begin
      if (state_r == ST_DONE) begin
        i_syn_r   <= sat8(acc_r);
        i_valid_r <= 1'b1;
        sat_r     <= is_clipped(acc_r);
      end else begin
        i_valid_r <= 1'b0;
        sat_r     <= 1'b0;
      end
    end
  end

  // Sticky overrun flag: enabled tick seen while a step is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_ovr_r <= 1'b0;
    end else begin
      if (tick && en && (state_r != ST_IDLE)) begin
        tick_ovr_r <= 1'b1;
      end
    end
  end

  assign cfg_ready = cfg_ready_r;
  assign i_syn     = i_syn_r;
  assign i_valid   = i_valid_r;
  assign sat       = sat_r;
  assign tick_ovr  = tick_ovr_r;

endmodule

// File: doc/qif_synapse.md
QIF_SYNAPSE -- requirements
Module: qif_synapse

Interface
REQ-001 SHALL have parameter NUM_IN, default 8, number of presynaptic spike lines.
REQ-002 SHALL have parameter DECAY_SHIFT, default 3, current leak shift per time step.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  block enable; low = ticks ignored.
REQ-006 SHALL have port tick  input  1  time-step strobe, one-cycle pulse.
REQ-007 SHALL have port spike_in  input  NUM_IN  presynaptic spike pulses, bit i = line i.
REQ-008 SHALL have port cfg_valid  input  1  weight-write request.
REQ-009 SHALL have port cfg_ready  output  1  weight-write accept.
REQ-010 SHALL have port cfg_addr  input  clog2(NUM_IN)  weight index.
REQ-011 SHALL have port cfg_data  input  8  signed weight value.
REQ-012 SHALL have port i_syn  output  8  signed synaptic current to the QIF neuron.
REQ-013 SHALL have port i_valid  output  1  one-cycle pulse when i_syn updates.
REQ-014 SHALL have port sat  output  1  one-cycle pulse, with i_valid, when the update clipped.
REQ-015 SHALL have port tick_ovr  output  1  sticky flag: tick arrived while busy.

Function
REQ-016 SHALL hold NUM_IN signed 8-bit weights; write w[cfg_addr]<=cfg_data when cfg_valid&&cfg_ready.
REQ-017 SHALL drive cfg_ready high only in IDLE; writes never change weights mid-update.
REQ-018 SHALL OR spike_in into a pending register every cycle; a spike between ticks is counted once per step, however many pulses occur.
REQ-019 SHALL use FSM IDLE -> ACCUM -> DONE -> IDLE.
REQ-020 IDLE: on tick&&en, snapshot pending, clear pending except bits set in spike_in that same cycle, load 12-bit acc with i_syn - (i_syn >>> DECAY_SHIFT) (arithmetic shift), and go to ACCUM with idx=0.
REQ-021 ACCUM: one cycle per line; acc += sign-extended w[idx] if snapshot[idx]; after idx=NUM_IN-1, go to DONE.
REQ-022 DONE: i_syn <= acc clipped to [-128,127]; pulse i_valid; pulse sat if clipped; return to IDLE.
REQ-023 Latency SHALL be fixed: i_valid asserts NUM_IN+2 cycles after the tick edge (10 for default).
REQ-024 A same-cycle cfg write and tick in IDLE: the write SHALL take effect, and the new weight SHALL be used in this step.
REQ-025 A tick outside IDLE, or with en low, SHALL be dropped; tick outside IDLE with en high sets tick_ovr.
REQ-026 en deasserted mid-update SHALL NOT abort the update in progress.
REQ-027 i_syn SHALL be stable between i_valid pulses; acc width SHALL not overflow (12 bits covers 8 x 8-bit + 8-bit).

Reset
REQ-028 On rst_n low, the block SHALL asynchronously set: state=IDLE, weights=0, pending=0, acc=0, i_syn=0, i_valid=0, sat=0, tick_ovr=0, and cfg_ready=0 while reset is asserted.
REQ-029 Reset asserted mid-ACCUM SHALL discard the update, with no i_valid pulse; after release, the first tick starts a clean step.

Structure
REQ-030 Shared package qif_pkg SHALL hold the FSM state type, the I_SYN_W=8 and ACC_W=12 constants, and the 8-bit saturate function.
REQ-031 Weight storage SHALL be one sub-module, qif_weight_rf: NUM_IN x 8 register file, one write port, one async read port.

Verification
REQ-032 w0=10, w3=-5, i_syn=0; spike lines 0 and 3, then tick at T -> i_valid at T+10, i_syn=5, sat=0.
REQ-033 i_syn=127, no spikes, tick -> i_syn=112; i_syn=-8, no spikes, tick -> i_syn=-7; i_syn=-1 -> 0.
REQ-034 All weights=127, all spikes, tick -> i_syn=127 and sat=1 with i_valid; all weights=-128 -> i_syn=-128 and sat=1.
REQ-035 Second tick at T+4 -> ignored, tick_ovr=1, single i_valid; spike on line 2 during ACCUM -> counted in the next step only.
REQ-036 cfg_valid held during ACCUM -> cfg_ready=0 and no write until IDLE; rst_n low at T+5 -> no i_valid, all outputs 0, weights 0.
